archer_projectile_ctl: RTL and testbench
========================================

// Module: archer_projectile_ctl
// PURPOSE
//  Archer projectile pool: spawns, moves, retires up to PROJECTILE_COUNT arrows.
//  Feeds archer_projectile_draw directly: packed pos_x_proj/pos_y_proj + projectile_animated.
//  Spawns at archer position on fire edge; moves once per frame_tick; retires on edge/range/hit.
// PARAMETERS
//  PROJECTILE_COUNT  vga_pkg::PROJECTILE_COUNT  number of slots
//  PROJ_SPEED        8     px moved per frame_tick
//  MAX_RANGE         64    frames of flight before retire (counter width 7)
//  COOLDOWN_FRAMES   20    frames between shots
//  X_MIN / X_MAX     0 / 1023  horizontal playfield limits (12-bit)
//  Y_MAX             767   bottom limit (used only with gravity)
// PORTS
//  clk                  in   1                     pixel clock
//  rst                  in   1                     sync active-high reset
//  frame_tick           in   1                     1-cycle strobe per frame
//  fire                 in   1                     attack button, level
//  game_active          in   2                     nonzero = running
//  char_class           in   2                     2 = archer
//  alive                in   1                     player alive
//  pos_x_archer         in   12                    spawn x
//  pos_y_archer         in   12                    spawn y
//  flip_hor_archer      in   1                     1 = facing left
//  projectile_hit       in   PROJECTILE_COUNT      per-slot hit, 1-cycle strobe
//  pos_x_proj           out  PROJECTILE_COUNT*12   slot i at [i*12+:12]
//  pos_y_proj           out  PROJECTILE_COUNT*12   slot i at [i*12+:12]
//  projectile_animated  out  PROJECTILE_COUNT      slot active
// BEHAVIOUR
//  - Clock clk; reset rst synchronous, active-high. All outputs registered.
//  - Reset: all pos=0, animated=0, dir=0, range cnt=0, cooldown=0, fire_d=0.
//  - enable = game_active!=0 && char_class==2 && alive. enable low: all slots
//    cleared next cycle (animated=0, pos held), cooldown=0; fire ignored.
//  - Fire edge = fire && !fire_d. Spawn when edge && cooldown==0 && free slot:
//    lowest-index free slot; x,y=archer pos; dir latched=flip_hor_archer; range=0;
//    animated=1 next cycle; cooldown=COOLDOWN_FRAMES.
//  - Pool full: fire edge ignored, cooldown unchanged. Held fire: no repeat.
//  - Cooldown decrements by 1 per frame_tick, saturates at 0.
//  - frame_tick, per active slot: x -= PROJ_SPEED if dir else x += PROJ_SPEED;
//    range++. Retire (animated=0) instead of moving if dir=1 && x < X_MIN+PROJ_SPEED,
//    dir=0 && x > X_MAX-PROJ_SPEED, or range==MAX_RANGE-1. No 12-bit wrap.
//  - Slot direction is fixed at spawn; later flips do not affect flight.
//  - Same cycle: hit beats move; spawn+tick -> new slot not moved that cycle;
//    retire and spawn can target the same slot only on the next cycle.
//  - Latency: fire edge -> animated high 1 cycle; tick -> new pos 1 cycle.
// CONFIGURATION
//  ARCHER_PROJ_GRAVITY_EN defined: y += 1 on every 4th tick of flight
//    (range[1:0]==3); retire when y >= Y_MAX.
//  Not defined: y constant at spawn value; Y_MAX unused.
// STRUCTURE
//  vga_pkg: PROJECTILE_COUNT, ARCHER_CLASS=2, PROJ_SPEED, COOLDOWN_FRAMES.
//  Sub-module archer_projectile_slot: one slot's pos/dir/range/retire logic.
//  Generate one per index; top keeps fire edge, cooldown, free-slot encoder.
// TESTING
//  1 rst; enable; fire pulse at (500,300), flip=0 -> slot0 animated, x=500;
//    3 ticks -> x=524, y=300.
//  2 flip=1 spawn x=20 -> ticks give 12, 4; next tick retires, no wrap to ~4092.
//  3 fire edges every frame with COOLDOWN_FRAMES=20 -> one spawn per 20 ticks;
//    fire held 100 ticks -> exactly one spawn.
//  4 fill all slots; extra fire -> ignored; hit slot1 + tick same cycle ->
//    slot1 retired, others moved; next fire -> slot1 reused.
//  5 range: spawn x=100, no edge hit -> retired after MAX_RANGE ticks;
//    alive=0 mid-flight -> all animated=0 next cycle.
//  6 GRAVITY_EN: after 8 ticks y=spawn+2; without macro y=spawn.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared playfield constants for the VGA game blocks.
package vga_pkg;

    localparam int         PROJECTILE_COUNT = 3;
    localparam logic [1:0] ARCHER_CLASS     = 2'd2;
    localparam int         PROJ_SPEED       = 8;
    localparam int         COOLDOWN_FRAMES  = 20;
    localparam int         COORD_W          = 12;
    localparam int         RANGE_W          = 7;

endpackage

// File: rtl/archer_projectile_slot.sv
// One arrow slot: spawn latch, per-frame motion, retirement on edge/range/hit.
// Optional ARCHER_PROJ_GRAVITY_EN adds a slow downward drift and a bottom limit.
module archer_projectile_slot
    import vga_pkg::*;
#(
    parameter int PROJ_SPEED = vga_pkg::PROJ_SPEED,
    parameter int MAX_RANGE  = 64,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 1023,
    parameter int Y_MAX      = 767
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_dir,
    input  logic               hit,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               animated
);

    localparam logic [COORD_W-1:0] SPEED      = COORD_W'(PROJ_SPEED);
    localparam logic [COORD_W-1:0] LEFT_LIM   = COORD_W'(X_MIN + PROJ_SPEED);
    localparam logic [COORD_W-1:0] RIGHT_LIM  = COORD_W'(X_MAX - PROJ_SPEED);
    localparam logic [RANGE_W-1:0] RANGE_LAST = RANGE_W'(MAX_RANGE - 1);

    logic               dir;
    logic [RANGE_W-1:0] range_cnt;
    logic               retire;

    // Retirement is decided on the pre-move position so the next step never wraps.
    always_comb begin
        retire = (dir && (pos_x < LEFT_LIM)) ||
                 (!dir && (pos_x > RIGHT_LIM)) ||
                 (range_cnt == RANGE_LAST);
`ifdef ARCHER_PROJ_GRAVITY_EN
        retire = retire || (pos_y >= COORD_W'(Y_MAX));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x     <= '0;
            pos_y     <= '0;
            dir       <= 1'b0;
            range_cnt <= '0;
            animated  <= 1'b0;
        end else if (!enable) begin
            animated <= 1'b0;
        end else if (animated) begin
            if (hit) begin
                animated <= 1'b0;
            end else if (frame_tick) begin
                if (retire) begin
                    animated <= 1'b0;
                end else begin
                    pos_x     <= dir ? (pos_x - SPEED) : (pos_x + SPEED);
                    range_cnt <= range_cnt + 1'b1;
`ifdef ARCHER_PROJ_GRAVITY_EN
                    if (range_cnt[1:0] == 2'd3)
                        pos_y <= pos_y + 1'b1;
`endif
                end
            end
        end else if (spawn) begin
            pos_x     <= spawn_x;
            pos_y     <= spawn_y;
            dir       <= spawn_dir;
            range_cnt <= '0;
            animated  <= 1'b1;
        end
    end

endmodule

// File: rtl/archer_projectile_ctl.sv
// Archer projectile pool: fire-edge detect, shot cooldown, lowest-free-slot spawn.
// Build option ARCHER_PROJ_GRAVITY_EN enables arrow drop inside each slot.
module archer_projectile_ctl
    import vga_pkg::*;
#(
    parameter int PROJECTILE_COUNT = vga_pkg::PROJECTILE_COUNT,
    parameter int PROJ_SPEED       = vga_pkg::PROJ_SPEED,
    parameter int MAX_RANGE        = 64,
    parameter int COOLDOWN_FRAMES  = vga_pkg::COOLDOWN_FRAMES,
    parameter int X_MIN            = 0,
    parameter int X_MAX            = 1023,
    parameter int Y_MAX            = 767
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  frame_tick,
    input  logic                                  fire,
    input  logic [1:0]                            game_active,
    input  logic [1:0]                            char_class,
    input  logic                                  alive,
    input  logic [COORD_W-1:0]                    pos_x_archer,
    input  logic [COORD_W-1:0]                    pos_y_archer,
    input  logic                                  flip_hor_archer,
    input  logic [PROJECTILE_COUNT-1:0]           projectile_hit,
    output logic [PROJECTILE_COUNT*COORD_W-1:0]   pos_x_proj,
    output logic [PROJECTILE_COUNT*COORD_W-1:0]   pos_y_proj,
    output logic [PROJECTILE_COUNT-1:0]           projectile_animated
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

    logic                        fire_d;
    logic [CD_W-1:0]             cooldown;
    logic                        enable;
    logic                        fire_edge;
    logic                        slot_found;
    logic [PROJECTILE_COUNT-1:0] free_sel;
    logic                        spawn_go;
    logic [PROJECTILE_COUNT-1:0] spawn_vec;

    assign enable    = (game_active != 2'd0) && (char_class == ARCHER_CLASS) && alive;
    assign fire_edge = fire && !fire_d;

    // Free slots come from the registered animated flags, so a slot retiring
    // this cycle only becomes spawnable on the next one.
    always_comb begin
        free_sel   = '0;
        slot_found = 1'b0;
        for (int i = 0; i < PROJECTILE_COUNT; i++) begin
            if (!projectile_animated[i] && !slot_found) begin
                free_sel[i] = 1'b1;
                slot_found  = 1'b1;
            end
        end
    end

    assign spawn_go  = enable && fire_edge && (cooldown == '0) && slot_found;
    assign spawn_vec = spawn_go ? free_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_d   <= 1'b0;
            cooldown <= '0;
        end else begin
            fire_d <= fire;
            if (!enable)
                cooldown <= '0;
            else if (spawn_go)
                cooldown <= CD_W'(COOLDOWN_FRAMES);
            else if (frame_tick && (cooldown != '0))
                cooldown <= cooldown - 1'b1;
        end
    end

    for (genvar g = 0; g < PROJECTILE_COUNT; g++) begin : g_slot
        archer_projectile_slot #(
            .PROJ_SPEED (PROJ_SPEED),
            .MAX_RANGE  (MAX_RANGE),
            .X_MIN      (X_MIN),
            .X_MAX      (X_MAX),
            .Y_MAX      (Y_MAX)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .frame_tick (frame_tick),
            .spawn      (spawn_vec[g]),
            .spawn_x    (pos_x_archer),
            .spawn_y    (pos_y_archer),
            .spawn_dir  (flip_hor_archer),
            .hit        (projectile_hit[g]),
            .pos_x      (pos_x_proj[g*COORD_W +: COORD_W]),
            .pos_y      (pos_y_proj[g*COORD_W +: COORD_W]),
            .animated   (projectile_animated[g])
        );
    end

endmodule

// File: tb/tb_archer_projectile_ctl.sv
// Scoreboard bench for archer_projectile_ctl: directed scenarios then random traffic.
module tb_archer_projectile_ctl;
    import vga_pkg::*;

    localparam int N    = PROJECTILE_COUNT;
    localparam int PS   = 8;
    localparam int MR   = 64;
    localparam int CD   = 20;
    localparam int XMIN = 0;
    localparam int XMAX = 1023;
    localparam int YMAX = 767;

    logic            clk = 1'b0;
    logic            rst, frame_tick, fire, alive, flip_hor_archer;
    logic [1:0]      game_active, char_class;
    logic [11:0]     pos_x_archer, pos_y_archer;
    logic [N-1:0]    projectile_hit;
    logic [N*12-1:0] pos_x_proj, pos_y_proj;
    logic [N-1:0]    projectile_animated;

    // values applied at the next falling edge
    logic            p_rst, p_alive, p_flip;
    logic [1:0]      p_ga, p_cc;
    logic [11:0]     p_x, p_y;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0]    a;
        logic [N*12-1:0] x;
        logic [N*12-1:0] y;
    } exp_t;
    exp_t sbq[$];

    // reference pool state
    int mx[N], my[N], mr[N];
    bit ma[N], md[N];
    int mcd;
    bit mfd;

    archer_projectile_ctl #(
        .PROJECTILE_COUNT (N), .PROJ_SPEED (PS), .MAX_RANGE (MR),
        .COOLDOWN_FRAMES (CD), .X_MIN (XMIN), .X_MAX (XMAX), .Y_MAX (YMAX)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_tick          (frame_tick),
        .fire                (fire),
        .game_active         (game_active),
        .char_class          (char_class),
        .alive               (alive),
        .pos_x_archer        (pos_x_archer),
        .pos_y_archer        (pos_y_archer),
        .flip_hor_archer     (flip_hor_archer),
        .projectile_hit      (projectile_hit),
        .pos_x_proj          (pos_x_proj),
        .pos_y_proj          (pos_y_proj),
        .projectile_animated (projectile_animated)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        bit en, fedge, retire;
        int fs;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mx[i] = 0; my[i] = 0; mr[i] = 0; ma[i] = 0; md[i] = 0;
            end
            mcd = 0; mfd = 0;
            return;
        end
        en    = (game_active != 0) && (char_class == 2) && alive;
        fedge = fire && !mfd;
        mfd   = fire;
        if (!en) begin
            for (int i = 0; i < N; i++) ma[i] = 0;
            mcd = 0;
            return;
        end
        fs = -1;
        for (int i = 0; i < N; i++) if (!ma[i] && fs < 0) fs = i;
        for (int i = 0; i < N; i++) begin
            if (!ma[i]) continue;
            if (projectile_hit[i]) ma[i] = 0;
            else if (frame_tick) begin
                retire = (md[i] && mx[i] < XMIN + PS) || (!md[i] && mx[i] > XMAX - PS)
                         || (mr[i] == MR - 1);
`ifdef ARCHER_PROJ_GRAVITY_EN
                retire = retire || (my[i] >= YMAX);
`endif
                if (retire) ma[i] = 0;
                else begin
`ifdef ARCHER_PROJ_GRAVITY_EN
                    if (mr[i] % 4 == 3) my[i] = my[i] + 1;
`endif
                    mx[i] = md[i] ? mx[i] - PS : mx[i] + PS;
                    mr[i] = mr[i] + 1;
                end
            end
        end
        if (fedge && mcd == 0 && fs >= 0) begin
            mx[fs] = pos_x_archer; my[fs] = pos_y_archer; md[fs] = flip_hor_archer;
            mr[fs] = 0; ma[fs] = 1; mcd = CD;
        end else if (frame_tick && mcd > 0) begin
            mcd = mcd - 1;
        end
    endfunction

    function automatic exp_t pack_model();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.a[i]         = ma[i];
            e.x[i*12 +: 12] = 12'(mx[i]);
            e.y[i*12 +: 12] = 12'(my[i]);
        end
        return e;
    endfunction

    task automatic cycle(input logic tk, input logic fr, input logic [N-1:0] hit);
        @(negedge clk);
        rst = p_rst; alive = p_alive; game_active = p_ga; char_class = p_cc;
        pos_x_archer = p_x; pos_y_archer = p_y; flip_hor_archer = p_flip;
        frame_tick = tk; fire = fr; projectile_hit = hit;
        model_step();
        sbq.push_back(pack_model());
    endtask

    task automatic ticks(input int n, input logic fr);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, fr, '0);
            cycle(1'b0, fr, '0);
        end
    endtask

    task automatic shoot();
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic clear_pool();
        p_alive = 1'b0;
        cycle(1'b0, 1'b0, '0);
        p_alive = 1'b1;
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: every post-edge output is compared with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (projectile_animated !== e.a) begin
                    errors++;
                    $display("FAIL sb_animated t=%0t actual=%b required=%b", $time, projectile_animated, e.a);
                end
                checks++;
                if (pos_x_proj !== e.x) begin
                    errors++;
                    $display("FAIL sb_pos_x t=%0t actual=%h required=%h", $time, pos_x_proj, e.x);
                end
                checks++;
                if (pos_y_proj !== e.y) begin
                    errors++;
                    $display("FAIL sb_pos_y t=%0t actual=%h required=%h", $time, pos_y_proj, e.y);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; frame_tick = 0; fire = 0; alive = 0; flip_hor_archer = 0;
        game_active = 0; char_class = 0; pos_x_archer = 0; pos_y_archer = 0;
        projectile_hit = '0;
        p_rst = 1'b1; p_alive = 1'b1; p_ga = 2'd1; p_cc = 2'd2;
        p_x = 12'd500; p_y = 12'd300; p_flip = 1'b0;

        cycle(0, 0, '0);
        cycle(0, 0, '0);
        sample();
        chk("reset_animated", int'(projectile_animated), 0);
        chk("reset_pos_x", int'(pos_x_proj[11:0]), 0);
        p_rst = 1'b0;

        // basic flight to the right
        cycle(0, 1, '0);
        sample();
        chk("spawn_animated", int'(projectile_animated), 1);
        chk("spawn_x", int'(pos_x_proj[11:0]), 500);
        cycle(0, 0, '0);
        ticks(3, 0);
        sample();
        chk("move_x", int'(pos_x_proj[11:0]), 524);
        chk("move_y", int'(pos_y_proj[11:0]), 300);

        // left flight near the edge retires without wrapping
        clear_pool();
        p_x = 12'd20; p_flip = 1'b1;
        shoot();
        p_flip = 1'b0;
        ticks(1, 0); sample(); chk("left_x1", int'(pos_x_proj[11:0]), 12);
        ticks(1, 0); sample(); chk("left_x2", int'(pos_x_proj[11:0]), 4);
        ticks(1, 0); sample();
        chk("left_retire", int'(projectile_animated[0]), 0);
        chk("left_nowrap", int'(pos_x_proj[11:0]), 4);

        // cooldown: edge every frame yields one spawn per 20 frames
        clear_pool();
        p_x = 12'd100;
        for (int f = 0; f < 60; f++) begin
            cycle(0, 1, '0);
            cycle(0, 0, '0);
            cycle(1, 0, '0);
        end
        sample();
        chk("cooldown_spawns", $countones(projectile_animated), 3);

        // held fire fires once, never repeats
        clear_pool();
        cycle(0, 1, '0);
        ticks(10, 1);
        sample();
        chk("held_one", $countones(projectile_animated), 1);
        ticks(90, 1);
        cycle(0, 0, '0);
        sample();
        chk("held_norepeat", $countones(projectile_animated), 0);

        // full pool, hit beats move, retired slot reused
        clear_pool();
        for (int s = 0; s < N; s++) begin
            shoot();
            ticks(CD, 0);
        end
        shoot();
        sample();
        chk("full_ignored", $countones(projectile_animated), N);
        cycle(1, 0, 3'b010);
        sample();
        chk("hit_retire", int'(projectile_animated), 3'b101);
        chk("hit_others_move", int'(pos_x_proj[11:0]), 100 + 61 * PS);
        shoot();
        sample();
        chk("reuse_slot1", int'(projectile_animated), 3'b111);
        chk("reuse_slot1_x", int'(pos_x_proj[23:12]), 100);

        // range limit, then disable mid-flight
        clear_pool();
        shoot();
        ticks(MR - 1, 0);
        sample();
        chk("range_alive", int'(projectile_animated[0]), 1);
        ticks(1, 0);
        sample();
        chk("range_retire", int'(projectile_animated[0]), 0);
        shoot();
        ticks(5, 0);
        p_alive = 1'b0;
        cycle(0, 0, '0);
        sample();
        chk("disable_clear", int'(projectile_animated), 0);
        p_alive = 1'b1;

        // vertical drift
        clear_pool();
        p_y = 12'd300;
        shoot();
        ticks(8, 0);
        sample();
`ifdef ARCHER_PROJ_GRAVITY_EN
        chk("gravity_y", int'(pos_y_proj[11:0]), 302);
`else
        chk("flat_y", int'(pos_y_proj[11:0]), 300);
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic tk, fr;
            logic [N-1:0] h;
            p_rst   = ($urandom_range(0, 499) == 0);
            p_alive = ($urandom_range(0, 59) != 0);
            p_ga    = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            p_cc    = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            p_x     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            p_y     = 12'($urandom_range(700, 800));
            p_flip  = 1'($urandom);
            tk      = ($urandom_range(0, 2) == 0);
            fr      = ($urandom_range(0, 3) == 0);
            h       = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            cycle(tk, fr, h);
        end
        p_rst = 1'b0;
        cycle(0, 0, '0);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
